// File: rtl/modexp_pkg.sv
// Shared types for the modular exponentiation controller.
// State encoding and default operand width.
// No logic; imported by modexp_ctrl.
package modexp_pkg;

    localparam int DATAWIDTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_M,
        ST_LOAD_X,
        ST_SQUARE,
        ST_MULT,
        ST_POST,
        ST_DONE
    } state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_t;

endpackage

// File: rtl/modexp_ctrl.sv
// C = M^E mod N by left-to-right square-and-multiply over an external Montgomery multiplier.
// Latency: DATAWIDTH + popcount(E) + 3 monpro ops, each op costs monpro latency + 2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; issue stalls on !mp_ready.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] i_M,
    input  logic [DATAWIDTH-1:0] i_E,
    input  logic [DATAWIDTH-1:0] i_N,
    input  logic [DATAWIDTH-1:0] i_R2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] o_C,
    output logic                 mp_start,
    input  logic                 mp_ready,
    input  logic                 mp_valid,
    output logic [DATAWIDTH-1:0] mp_A,
    output logic [DATAWIDTH-1:0] mp_B,
    output logic [DATAWIDTH-1:0] mp_N,
    input  logic [DATAWIDTH-1:0] mp_U
);

    localparam int CW = $clog2(DATAWIDTH);
    localparam logic [DATAWIDTH-1:0] ONE     = DATAWIDTH'(1);
    localparam logic [CW-1:0]        TOP_BIT = CW'(DATAWIDTH - 1);

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]   m_q, m_d, e_q, e_d, n_q, n_d, r2_q, r2_d;
    logic [DATAWIDTH-1:0]   mbar_q, mbar_d, xbar_q, xbar_d, c_q, c_d;
    logic [DATAWIDTH-1:0]   mp_a_q, mp_a_d, mp_b_q, mp_b_d, mp_n_q, mp_n_d;
    logic                   mp_start_q, mp_start_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0]   op_a, op_b;
    logic                   mp_done;
    logic                   bit_step;

    // Operands of the op owned by the current state, in Montgomery form.
    always_comb begin
        op_a = xbar_q;
        op_b = xbar_q;
        case (state_q)
            ST_LOAD_M: begin op_a = m_q; op_b = r2_q; end
            ST_LOAD_X: begin op_a = ONE; op_b = r2_q; end
            ST_MULT:   op_a = mbar_q;
            ST_POST:   op_b = ONE;
            default:   ;
        endcase
    end

    // A result pulse coinciding with our own start cannot belong to this op.
    assign mp_done = (phase_q == PH_WAIT) && mp_valid && !mp_start_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        e_d        = e_q;
        n_d        = n_q;
        r2_d       = r2_q;
        mbar_d     = mbar_q;
        xbar_d     = xbar_q;
        c_d        = c_q;
        mp_a_d     = mp_a_q;
        mp_b_d     = mp_b_q;
        mp_n_d     = mp_n_q;
        mp_start_d = 1'b0;
        bit_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    m_d     = i_M;
                    e_d     = i_E;
                    n_d     = i_N;
                    r2_d    = i_R2;
                    cnt_d   = TOP_BIT;
                    phase_d = PH_ISSUE;
                    state_d = ST_LOAD_M;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: begin
                if (phase_q == PH_ISSUE) begin
                    if (mp_ready) begin
                        mp_a_d     = op_a;
                        mp_b_d     = op_b;
                        mp_n_d     = n_q;
                        mp_start_d = 1'b1;
                        phase_d    = PH_WAIT;
                    end
                end else if (mp_done) begin
                    phase_d = PH_ISSUE;
                    case (state_q)
                        ST_LOAD_M: begin mbar_d = mp_U; state_d = ST_LOAD_X; end
                        ST_LOAD_X: begin xbar_d = mp_U; state_d = ST_SQUARE; end
                        ST_SQUARE: begin
                            xbar_d = mp_U;
                            if (e_q[cnt_q]) state_d = ST_MULT;
                            else            bit_step = 1'b1;
                        end
                        ST_MULT:   begin xbar_d = mp_U; bit_step = 1'b1; end
                        ST_POST:   begin c_d = mp_U; state_d = ST_DONE; end
                        default:   ;
                    endcase
                    if (bit_step) begin
                        if (cnt_q == '0) begin
                            state_d = ST_POST;
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = ST_SQUARE;
                        end
                    end
                end
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_ISSUE;
            cnt_q       <= '0;
            m_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            r2_q        <= '0;
            mbar_q      <= '0;
            xbar_q      <= '0;
            c_q         <= '0;
            mp_a_q      <= '0;
            mp_b_q      <= '0;
            mp_n_q      <= '0;
            mp_start_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            e_q         <= e_d;
            n_q         <= n_d;
            r2_q        <= r2_d;
            mbar_q      <= mbar_d;
            xbar_q      <= xbar_d;
            c_q         <= c_d;
            mp_a_q      <= mp_a_d;
            mp_b_q      <= mp_b_d;
            mp_n_q      <= mp_n_d;
            mp_start_q  <= mp_start_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o_C       = c_q;
    assign mp_start  = mp_start_q;
    assign mp_A      = mp_a_q;
    assign mp_B      = mp_b_q;
    assign mp_N      = mp_n_q;

endmodule
